// File: rtl/decoder_pkg.sv
// Shared definitions for the registered one-hot decoders: state encoding and index decode.
package decoder_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    localparam int unsigned HOLD_CNT_W = 8;

    typedef enum logic {
        StIdle = ST_IDLE,
        StHold = ST_HOLD
    } state_e;

    function automatic logic [3:0] onehot_2to4(input logic [1:0] idx);
        logic [3:0] vec;
        vec = 4'b0000;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/hold_counter.sv
// 8-bit down-counter with synchronous load and a zero flag; stops at zero.
module hold_counter
    import decoder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [HOLD_CNT_W-1:0] load_val,
    input  logic                  dec,
    output logic                  zero
);

    logic [HOLD_CNT_W-1:0] cnt_q;
    logic [HOLD_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb zero = (cnt_q == '0);

endmodule

// File: rtl/decoder2x4_hold.sv
// Registered 2-to-4 decoder that holds each accepted code for HOLD_CYCLES cycles,
// back-pressuring upstream while holding and counting transfers that carry v=0.
module decoder2x4_hold
    import decoder_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       code,
    input  logic             v,
    output logic [3:0]       y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] none_cnt
);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
            $error("decoder2x4_hold: HOLD_CYCLES must be in 1..255");
        end
    endgenerate

    // Counter is loaded with HOLD_CYCLES-1 so the exit edge is the one seeing zero.
    localparam logic [HOLD_CNT_W-1:0] HoldLoad = HOLD_CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       y_q, y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] none_q, none_d;
    logic             cnt_load, cnt_dec, cnt_zero;

    hold_counter u_hold_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (HoldLoad),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        none_d   = none_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        in_ready = (state_q == StIdle);

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (v) begin
                        y_d      = onehot_2to4(code);
                        busy_d   = 1'b1;
                        cnt_load = 1'b1;
                        state_d  = StHold;
                    end else if (none_q != '1) begin
                        none_d = none_q + 1'b1;
                    end
                end
            end
            StHold: begin
                if (cnt_zero) begin
                    y_d     = 4'b0000;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                y_d     = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            y_q     <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            none_q  <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            none_q  <= none_d;
        end
    end

    always_comb begin
        y        = y_q;
        busy     = busy_q;
        done     = done_q;
        none_cnt = none_q;
    end

endmodule

// File: tb/tb_decoder2x4_hold.sv
// Directed bench for decoder2x4_hold: one instance with HOLD_CYCLES=4/CNT_W=2, one with HOLD_CYCLES=1.
module tb_decoder2x4_hold;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] code = 2'd0;
    logic       v = 1'b0;
    logic [3:0] y;
    logic       busy;
    logic       done;
    logic [1:0] none_cnt;

    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic [1:0] code1 = 2'd0;
    logic       v1 = 1'b0;
    logic [3:0] y1;
    logic       busy1;
    logic       done1;
    logic [7:0] none_cnt1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decoder2x4_hold #(.HOLD_CYCLES(4), .CNT_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .code     (code),
        .v        (v),
        .y        (y),
        .busy     (busy),
        .done     (done),
        .none_cnt (none_cnt)
    );

    decoder2x4_hold #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid1),
        .in_ready (in_ready1),
        .code     (code1),
        .v        (v1),
        .y        (y1),
        .busy     (busy1),
        .done     (done1),
        .none_cnt (none_cnt1)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({y, busy, done, none_cnt, in_ready} !== {4'b0000, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset: y=%b busy=%b done=%b none=%0d rdy=%b, want 0000 0 0 0 1",
                     y, busy, done, none_cnt, in_ready);
        end
        n_cmp++;
        if ({y1, busy1, done1, none_cnt1, in_ready1} !== {4'b0000, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_dut1: y=%b busy=%b done=%b none=%0d rdy=%b, want 0000 0 0 0 1",
                     y1, busy1, done1, none_cnt1, in_ready1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_hold();
        in_valid = 1'b1; code = 2'b10; v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
            n_cmp++;
            if ({y, busy, in_ready, done} !== {4'b0100, 1'b1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL hold_cycle%0d: y=%b busy=%b rdy=%b done=%b, want 0100 1 0 0",
                         i, y, busy, in_ready, done);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({y, busy, in_ready, done} !== {4'b0000, 1'b0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL hold_exit: y=%b busy=%b rdy=%b done=%b, want 0000 0 1 1",
                     y, busy, in_ready, done);
        end
        @(negedge clk);
        n_cmp++;
        if ({y, done} !== {4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL done_pulse: y=%b done=%b, want 0000 0", y, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_y [4];
        exp_y = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        in_valid = 1'b1; code = 2'd0; v = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (i == 0) code = 2'(k + 1);
                n_cmp++;
                if ({y, busy, in_ready, done} !== {exp_y[k], 1'b1, 1'b0, 1'b0}) begin
                    n_err++;
                    $display("FAIL b2b_code%0d_cyc%0d: y=%b busy=%b rdy=%b done=%b, want %b 1 0 0",
                             k, i, y, busy, in_ready, done, exp_y[k]);
                end
            end
            @(negedge clk);
            if (k == 3) in_valid = 1'b0;
            n_cmp++;
            if ({y, in_ready, done} !== {4'b0000, 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL b2b_gap%0d: y=%b rdy=%b done=%b, want 0000 1 1",
                         k, y, in_ready, done);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({y, busy, done} !== {4'b0000, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_end: y=%b busy=%b done=%b, want 0000 0 0", y, busy, done);
        end
    endtask

    task automatic test_none_count();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        in_valid = 1'b1; code = 2'd1; v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) in_valid = 1'b0;
            n_cmp++;
            if ({none_cnt, y, busy, in_ready} !== {exp_cnt[i], 4'b0000, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL none_cnt%0d: cnt=%0d y=%b busy=%b rdy=%b, want %0d 0000 0 1",
                         i, none_cnt, y, busy, in_ready, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        in_valid = 1'b1; code = 2'd3; v = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (y !== 4'b1000) begin
            n_err++;
            $display("FAIL midrst_pre: y=%b, want 1000", y);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({y, busy, done, none_cnt} !== {4'b0000, 1'b0, 1'b0, 2'd0}) begin
            n_err++;
            $display("FAIL midrst_async: y=%b busy=%b done=%b none=%0d, want 0000 0 0 0",
                     y, busy, done, none_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; code = 2'd1; v = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if ({y, busy} !== {4'b0010, 1'b1}) begin
            n_err++;
            $display("FAIL midrst_after: y=%b busy=%b, want 0010 1", y, busy);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_hold_one();
        in_valid1 = 1'b1; code1 = 2'd0; v1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ((i % 2) == 0) begin
                if ({y1, busy1, done1, in_ready1} !== {4'b0001, 1'b1, 1'b0, 1'b0}) begin
                    n_err++;
                    $display("FAIL hold1_on%0d: y=%b busy=%b done=%b rdy=%b, want 0001 1 0 0",
                             i, y1, busy1, done1, in_ready1);
                end
            end else begin
                if ({y1, busy1, done1, in_ready1} !== {4'b0000, 1'b0, 1'b1, 1'b1}) begin
                    n_err++;
                    $display("FAIL hold1_off%0d: y=%b busy=%b done=%b rdy=%b, want 0000 0 1 1",
                             i, y1, busy1, done1, in_ready1);
                end
            end
        end
        in_valid1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_hold();
        test_back_to_back();
        test_none_count();
        test_reset_mid_hold();
        test_hold_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decoder2x4_hold.md
# decoder2x4_hold

- Registered 2-to-4 decoder with pulse-stretch hold. It takes the 2-bit code plus valid bit produced by the lab's 4-to-2 encoder and drives a one-hot 4-bit output.
- Each accepted code is held for a fixed number of cycles, long enough for LEDs or downstream logic to observe it.
- A simple valid/ready handshake back-pressures the encoder side while a code is being held.
- Codes arriving with the valid bit low are counted, not decoded.

## Interface
Parameters:
- HOLD_CYCLES, 4, cycles each decoded one-hot output stays asserted; legal range 1..255
- CNT_W, 8, width of the none-request counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream presents code/v this cycle
- in_ready  out  1  block can accept; combinational, high only in IDLE
- code  in  2  encoded index; code[1] = Q1, code[0] = Q0
- v  in  1  encoder valid bit (some input line active)
- y  out  4  one-hot decoded output, registered
- busy  out  1  high while in HOLD
- done  out  1  one-cycle pulse on the first IDLE cycle after a HOLD
- none_cnt  out  CNT_W  saturating count of accepted transfers with v=0

## Operation
- Clocking and reset: one clock domain; reset is asynchronous, active-low.
- Reset values: state=IDLE, y=4'b0000, busy=0, done=0, none_cnt=0, hold counter=0.
- Transfer: happens on a rising edge where in_valid && in_ready.
- States: IDLE and HOLD.
- IDLE, transfer with v=1:
  - y <= 1 << code (code 0 -> y=0001, 1 -> 0010, 2 -> 0100, 3 -> 1000).
  - Hold counter <= HOLD_CYCLES-1.
  - Next state = HOLD.
- IDLE, transfer with v=0:
  - y stays 0000; state stays IDLE.
  - none_cnt increments, saturating at all-ones (never wraps).
- IDLE, no transfer: all registers hold; done <= 0.
- HOLD:
  - in_ready=0; upstream code/v ignored.
  - y held; counter decrements each edge.
  - On the edge where counter==0: y <= 0000, busy <= 0, done <= 1, next state = IDLE.
- done is a registered pulse, high for exactly one cycle; it clears on the following edge.
- busy is registered and equals (state==HOLD).
- y is never multi-hot. y is all-zero in IDLE.
- Out-of-range HOLD_CYCLES (0 or >255) is a static elaboration error.

## Timing
- Latency: y updates on the accepting edge, so it is visible the cycle after in_valid is sampled.
- Duration: y remains one-hot for exactly HOLD_CYCLES clock cycles.
- Back-to-back: in_ready returns high in the same cycle y returns to 0 and done=1. A new transfer in that cycle puts the next one-hot on y the following cycle. There is exactly one all-zero gap cycle between consecutive holds.
- HOLD_CYCLES=1: HOLD lasts one cycle; peak accept rate is one code every 2 cycles.
- in_valid high during HOLD: no transfer; upstream must keep in_valid/code/v stable until in_ready.
- Reset mid-HOLD: y, busy and done drop to 0 immediately (asynchronously); none_cnt clears; first accept possible on the first edge after rst_n deasserts.
- none_cnt saturation: a v=0 transfer at all-ones leaves the count at all-ones.

## Structure
- Shared package/header decoder_pkg:
  - State encoding localparams ST_IDLE=1'b0, ST_HOLD=1'b1.
  - One-hot decode function for 2-bit index to 4-bit vector; shared with future 3-to-8 variants.
- One natural sub-module, hold_counter: 8-bit down-counter with load and a zero flag.
- Top: FSM, y/done/busy registers, none_cnt.

## Test plan
- Reset then idle: rst_n low 3 cycles -> y=0000, busy=0, done=0, none_cnt=0, in_ready=1.
- HOLD_CYCLES=4, transfer code=2'b10, v=1 -> y=0100 for exactly 4 cycles, busy=1 throughout, in_ready=0; then y=0000 with done=1 for 1 cycle.
- Sweep codes 0..3 back-to-back, in_valid held high -> y sequence 0001, 0010, 0100, 1000. Each lasts 4 cycles, separated by one 0000 cycle with done=1.
- v=0 transfers, CNT_W=2, 5 transfers -> y stays 0000, none_cnt 1,2,3,3,3; state never leaves IDLE.
- Assert rst_n low 2 cycles into a HOLD of code 3 -> y drops to 0000 asynchronously; after release, code 1 accepted -> y=0010.
- HOLD_CYCLES=1, continuous valid code 0 -> y alternates 0001/0000 every cycle, done high on each 0000 cycle.
